// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// sticky illegal-instruction and memory-timeout traps, and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          ENABLE_SLT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [4:0]  rt,
  input  logic [8:0]  zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCsrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemToReg,
  output logic        AluSrc,
  output logic        ExtOp,
  output logic        we,
  output logic        memread,
  output logic        memwrite,
  output logic        slts_real,
  output logic [2:0]  AluOp,
  output logic [2:0]  state,
  output logic        trap,
  output logic        bus_err,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [4:0] {
    I_ADDU  = 5'd0,  I_SUBU  = 5'd1,  I_ORI   = 5'd2,  I_LUI   = 5'd3,
    I_LW    = 5'd4,  I_SW    = 5'd5,  I_BEQ   = 5'd6,  I_BNE   = 5'd7,
    I_BGEZ  = 5'd8,  I_BGTZ  = 5'd9,  I_BLEZ  = 5'd10, I_BLTZ  = 5'd11,
    I_JR    = 5'd12, I_JAL   = 5'd13, I_SLT   = 5'd14, I_SLTU  = 5'd15,
    I_SLTI  = 5'd16, I_SLTIU = 5'd17, I_ILL   = 5'd31
  } ins_t;

  localparam logic [2:0]  ALU_ADD   = 3'b000;
  localparam logic [2:0]  ALU_SUB   = 3'b001;
  localparam logic [2:0]  ALU_OR    = 3'b011;
  localparam logic [2:0]  ALU_LUI   = 3'b100;
  localparam logic [15:0] TIMEOUT_W = TIMEOUT[15:0];

  // Classify the instruction register fields; anything unrecognised is illegal.
  function automatic ins_t decode_ins(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] r);
    ins_t k;
    k = I_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001: k = I_ADDU;
          6'b100011: k = I_SUBU;
          6'b001000: k = I_JR;
          6'b101010: k = ENABLE_SLT ? I_SLT : I_ILL;
          6'b101011: k = ENABLE_SLT ? I_SLTU : I_ILL;
          default:   k = I_ILL;
        endcase
      end
      6'b000001: begin
        if (r == 5'b00001) begin
          k = I_BGEZ;
        end else if (r == 5'b00000) begin
          k = I_BLTZ;
        end else begin
          k = I_ILL;
        end
      end
      6'b001101: k = I_ORI;
      6'b001111: k = I_LUI;
      6'b100011: k = I_LW;
      6'b101011: k = I_SW;
      6'b000100: k = I_BEQ;
      6'b000101: k = I_BNE;
      6'b000111: k = I_BGTZ;
      6'b000110: k = I_BLEZ;
      6'b000011: k = I_JAL;
      6'b001010: k = ENABLE_SLT ? I_SLTI : I_ILL;
      6'b001011: k = ENABLE_SLT ? I_SLTIU : I_ILL;
      default:   k = I_ILL;
    endcase
    return k;
  endfunction

  state_t      state_q, state_d;
  ins_t        ins_q, ins_d;
  logic [15:0] wait_q, wait_d;
  logic        trap_q, trap_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] cnt_q, cnt_d;

  logic [15:0] wait_inc_s;
  logic        timeout_s;
  logic        taken_s;
  logic        rtype_s;
  logic        slt_s;
  logic        sltu_s;

  logic        ir_s, pc_s, alusrc_s, extop_s, we_s, mrd_s, mwr_s, slts_s;
  logic [1:0]  pcsrc_s, regdst_s, mtr_s;
  logic [2:0]  aluop_s;

  logic        unused_zero_s;
  assign unused_zero_s = ^{zero[8:7], zero[5]};

  // The wait counter saturates rather than wrapping so a huge TIMEOUT cannot be skipped.
  assign wait_inc_s = (wait_q == 16'hFFFF) ? wait_q : (wait_q + 16'd1);
  assign timeout_s  = (wait_inc_s == TIMEOUT_W);

  assign rtype_s = (ins_q == I_ADDU) || (ins_q == I_SUBU) ||
                   (ins_q == I_SLT)  || (ins_q == I_SLTU);
  assign slt_s   = (ins_q == I_SLT)  || (ins_q == I_SLTI);
  assign sltu_s  = (ins_q == I_SLTU) || (ins_q == I_SLTIU);

  // Branch condition from the ALU flags of the latched instruction.
  always_comb begin
    taken_s = 1'b0;
    case (ins_q)
      I_BEQ:   taken_s = zero[4];
      I_BNE:   taken_s = ~zero[4];
      I_BGEZ:  taken_s = zero[2] | zero[1];
      I_BGTZ:  taken_s = zero[2];
      I_BLEZ:  taken_s = zero[1] | zero[0];
      I_BLTZ:  taken_s = zero[0];
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state, sticky flags, counters and per-state control strobes.
  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    wait_d    = 16'd0;
    trap_d    = trap_q;
    bus_err_d = bus_err_q;
    cnt_d     = cnt_q;
    ir_s      = 1'b0;
    pc_s      = 1'b0;
    pcsrc_s   = 2'b00;
    regdst_s  = 2'b00;
    mtr_s     = 2'b00;
    alusrc_s  = 1'b0;
    extop_s   = 1'b0;
    we_s      = 1'b0;
    mrd_s     = 1'b0;
    mwr_s     = 1'b0;
    slts_s    = 1'b0;
    aluop_s   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mrd_s = 1'b1;
        if (mem_ready) begin
          ir_s    = 1'b1;
          pc_s    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_DECODE: begin
        ins_d = decode_ins(opcode, func, rt);
        if (ins_d == I_ILL) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ins_q)
          I_BEQ, I_BNE, I_BGEZ, I_BGTZ, I_BLEZ, I_BLTZ: begin
            extop_s = 1'b1;
            aluop_s = ALU_SUB;
            state_d = S_FETCH;
            cnt_d   = cnt_q + 32'd1;
            if (taken_s) begin
              pc_s    = 1'b1;
              pcsrc_s = 2'b01;
            end else begin
              pcsrc_s = 2'b00;
            end
          end
          I_JR: begin
            pc_s    = 1'b1;
            pcsrc_s = 2'b11;
            state_d = S_FETCH;
            cnt_d   = cnt_q + 32'd1;
          end
          I_JAL: begin
            pc_s     = 1'b1;
            pcsrc_s  = 2'b10;
            we_s     = 1'b1;
            regdst_s = 2'b10;
            mtr_s    = 2'b10;
            state_d  = S_FETCH;
            cnt_d    = cnt_q + 32'd1;
          end
          I_LW, I_SW: begin
            alusrc_s = 1'b1;
            extop_s  = 1'b1;
            state_d  = S_MEM;
          end
          I_ADDU: state_d = S_WB;
          I_SUBU: begin
            aluop_s = ALU_SUB;
            state_d = S_WB;
          end
          I_ORI: begin
            alusrc_s = 1'b1;
            aluop_s  = ALU_OR;
            state_d  = S_WB;
          end
          I_LUI: begin
            alusrc_s = 1'b1;
            aluop_s  = ALU_LUI;
            state_d  = S_WB;
          end
          I_SLT, I_SLTU: begin
            aluop_s = ALU_SUB;
            state_d = S_WB;
          end
          I_SLTI, I_SLTIU: begin
            alusrc_s = 1'b1;
            extop_s  = 1'b1;
            aluop_s  = ALU_SUB;
            state_d  = S_WB;
          end
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (ins_q == I_LW) begin
          mrd_s = 1'b1;
        end else begin
          mwr_s = 1'b1;
        end
        if (mem_ready) begin
          if (ins_q == I_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + 32'd1;
          end
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_WB: begin
        we_s     = 1'b1;
        regdst_s = rtype_s ? 2'b01 : 2'b00;
        if (ins_q == I_LW) begin
          mtr_s = 2'b01;
        end else if (slt_s || sltu_s) begin
          mtr_s = 2'b11;
        end else begin
          mtr_s = 2'b00;
        end
        slts_s  = (slt_s & zero[3]) | (sltu_s & zero[6]);
        state_d = S_FETCH;
        cnt_d   = cnt_q + 32'd1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ins_q     <= I_ILL;
      wait_q    <= 16'd0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobes follow mem_ready within the cycle, so they are gated by reset directly
  // to keep memread low while reset is held.
  assign IRWrite   = ir_s     & ~reset;
  assign PCWrite   = pc_s     & ~reset;
  assign PCsrc     = reset ? 2'b00 : pcsrc_s;
  assign RegDst    = reset ? 2'b00 : regdst_s;
  assign MemToReg  = reset ? 2'b00 : mtr_s;
  assign AluSrc    = alusrc_s & ~reset;
  assign ExtOp     = extop_s  & ~reset;
  assign we        = we_s     & ~reset;
  assign memread   = mrd_s    & ~reset;
  assign memwrite  = mwr_s    & ~reset;
  assign slts_real = slts_s   & ~reset;
  assign AluOp     = reset ? 3'b000 : aluop_s;
  assign state     = state_q;
  assign trap      = trap_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expected controls, a negedge monitor
// pops and compares them against the selected controller instance.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir;
    logic        pc;
    logic [1:0]  pcsrc;
    logic [1:0]  regdst;
    logic [1:0]  mtr;
    logic        alusrc;
    logic        extop;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic        slts;
    logic [2:0]  aluop;
    logic        trap;
    logic        berr;
    logic [31:0] cnt;
  } obs_t;

  localparam logic [8:0] Z = 9'h000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic [4:0] rt = 5'd0;
  logic [8:0] zero = 9'd0;
  logic       mem_ready = 1'b0;

  logic [5:0] nxt_op = 6'd0;
  logic [5:0] nxt_fn = 6'd0;
  logic [4:0] nxt_rt = 5'd0;
  bit         sel = 1'b0;

  logic a_ir, a_pc, a_as, a_ext, a_we, a_mrd, a_mwr, a_slts, a_trap, a_berr;
  logic [1:0] a_pcsrc, a_rd, a_mtr;
  logic [2:0] a_aop, a_st;
  logic [31:0] a_cnt;
  logic b_ir, b_pc, b_as, b_ext, b_we, b_mrd, b_mwr, b_slts, b_trap, b_berr;
  logic [1:0] b_pcsrc, b_rd, b_mtr;
  logic [2:0] b_aop, b_st;
  logic [31:0] b_cnt;
  obs_t obs_a, obs_b;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(4), .ENABLE_SLT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .rt(rt), .zero(zero),
    .mem_ready(mem_ready), .IRWrite(a_ir), .PCWrite(a_pc), .PCsrc(a_pcsrc),
    .RegDst(a_rd), .MemToReg(a_mtr), .AluSrc(a_as), .ExtOp(a_ext), .we(a_we),
    .memread(a_mrd), .memwrite(a_mwr), .slts_real(a_slts), .AluOp(a_aop),
    .state(a_st), .trap(a_trap), .bus_err(a_berr), .instr_cnt(a_cnt)
  );

  multicycle_controller #(.TIMEOUT(255), .ENABLE_SLT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .rt(rt), .zero(zero),
    .mem_ready(mem_ready), .IRWrite(b_ir), .PCWrite(b_pc), .PCsrc(b_pcsrc),
    .RegDst(b_rd), .MemToReg(b_mtr), .AluSrc(b_as), .ExtOp(b_ext), .we(b_we),
    .memread(b_mrd), .memwrite(b_mwr), .slts_real(b_slts), .AluOp(b_aop),
    .state(b_st), .trap(b_trap), .bus_err(b_berr), .instr_cnt(b_cnt)
  );

  assign obs_a = {a_st, a_ir, a_pc, a_pcsrc, a_rd, a_mtr, a_as, a_ext, a_we, a_mrd,
                  a_mwr, a_slts, a_aop, a_trap, a_berr, a_cnt};
  assign obs_b = {b_st, b_ir, b_pc, b_pcsrc, b_rd, b_mtr, b_as, b_ext, b_we, b_mrd,
                  b_mwr, b_slts, b_aop, b_trap, b_berr, b_cnt};

  obs_t  exp_q[$];
  string tag_q[$];
  bit    sel_q[$];
  int    checks = 0;
  int    passed = 0;

  obs_t  mon_e, mon_a;
  string mon_t;
  bit    mon_s;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_s = sel_q.pop_front();
      mon_a = mon_s ? obs_b : obs_a;
      checks++;
      if (mon_a === mon_e) begin
        passed++;
      end else begin
        $display("FAIL %s: got st=%0d cnt=%0d ctl=%h, expected st=%0d cnt=%0d ctl=%h",
                 mon_t, mon_a.st, mon_a.cnt, mon_a, mon_e.st, mon_e.cnt, mon_e);
      end
    end
  end

  function automatic obs_t mk(input logic [2:0] st, input logic [1:0] pcsrc,
                              input logic [1:0] rd, input logic [1:0] mtr,
                              input logic pc, input logic as, input logic ext,
                              input logic w, input logic mrd, input logic mwr,
                              input logic slts, input logic [2:0] aop,
                              input logic [31:0] cnt);
    obs_t e;
    e = '0;
    e.st = st; e.pcsrc = pcsrc; e.regdst = rd; e.mtr = mtr; e.pc = pc;
    e.alusrc = as; e.extop = ext; e.we = w; e.mrd = mrd; e.mwr = mwr;
    e.slts = slts; e.aluop = aop; e.cnt = cnt;
    return e;
  endfunction

  function automatic obs_t fetch(input logic done, input logic [31:0] cnt);
    obs_t e;
    e = '0;
    e.ir = done; e.pc = done; e.mrd = 1'b1; e.cnt = cnt;
    return e;
  endfunction

  function automatic obs_t dec(input logic [31:0] cnt);
    obs_t e;
    e = '0;
    e.st = 3'd1; e.cnt = cnt;
    return e;
  endfunction

  function automatic obs_t trp(input logic t, input logic b, input logic [31:0] cnt);
    obs_t e;
    e = '0;
    e.st = 3'd5; e.trap = t; e.berr = b; e.cnt = cnt;
    return e;
  endfunction

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    nxt_op = op; nxt_fn = fn; nxt_rt = r;
  endtask

  task automatic cyc(input logic [8:0] z, input logic mr, input obs_t e, input string t);
    @(posedge clk); #1;
    reset = 1'b0; opcode = nxt_op; func = nxt_fn; rt = nxt_rt;
    zero = z; mem_ready = mr;
    exp_q.push_back(e); tag_q.push_back(t); sel_q.push_back(sel);
  endtask

  task automatic do_reset(input string t);
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b0; zero = Z;
    exp_q.push_back('0); tag_q.push_back(t); sel_q.push_back(sel);
  endtask

  initial begin
    do_reset("reset_state");
    // addu: 0,1,2,4 then retire
    set_ins(6'b000000, 6'b100001, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd0), "addu_fetch");
    cyc(Z, 1'b1, dec(32'd0), "addu_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0), "addu_exec");
    cyc(Z, 1'b1, mk(3'd4, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0), "addu_wb");
    // lw with three not-ready cycles in MEM
    set_ins(6'b100011, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd1), "lw_fetch");
    cyc(Z, 1'b1, dec(32'd1), "lw_decode");
    cyc(Z, 1'b0, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd1), "lw_exec");
    for (int i = 0; i < 4; i++)
      cyc(Z, (i == 3) ? 1'b1 : 1'b0, mk(3'd3, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd1), "lw_mem");
    cyc(Z, 1'b1, mk(3'd4, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd1), "lw_wb");
    // beq not taken, then taken
    set_ins(6'b000100, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd2), "beq0_fetch");
    cyc(Z, 1'b1, dec(32'd2), "beq0_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd2), "beq_not_taken");
    cyc(Z, 1'b1, fetch(1'b1, 32'd3), "beq1_fetch");
    cyc(Z, 1'b1, dec(32'd3), "beq1_decode");
    cyc(9'h010, 1'b1, mk(3'd2, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd3), "beq_taken");
    // bgez taken on A==0, bltz not taken on A==0
    set_ins(6'b000001, 6'd0, 5'b00001);
    cyc(Z, 1'b1, fetch(1'b1, 32'd4), "bgez_fetch");
    cyc(Z, 1'b1, dec(32'd4), "bgez_decode");
    cyc(9'h002, 1'b1, mk(3'd2, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd4), "bgez_taken");
    set_ins(6'b000001, 6'd0, 5'b00000);
    cyc(Z, 1'b1, fetch(1'b1, 32'd5), "bltz_fetch");
    cyc(Z, 1'b1, dec(32'd5), "bltz_decode");
    cyc(9'h002, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd5), "bltz_not_taken");
    // jal, jr
    set_ins(6'b000011, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd6), "jal_fetch");
    cyc(Z, 1'b1, dec(32'd6), "jal_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd6), "jal_exec");
    set_ins(6'b000000, 6'b001000, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd7), "jr_fetch");
    cyc(Z, 1'b1, dec(32'd7), "jr_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd7), "jr_exec");
    // sltu with unsigned-less flag, slti with only the unsigned flag set
    set_ins(6'b000000, 6'b101011, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd8), "sltu_fetch");
    cyc(Z, 1'b1, dec(32'd8), "sltu_decode");
    cyc(9'h040, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd8), "sltu_exec");
    cyc(9'h040, 1'b1, mk(3'd4, 2'b00, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd8), "sltu_wb");
    set_ins(6'b001010, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd9), "slti_fetch");
    cyc(Z, 1'b1, dec(32'd9), "slti_decode");
    cyc(9'h040, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd9), "slti_exec");
    cyc(9'h040, 1'b1, mk(3'd4, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd9), "slti_wb");
    // ori, then sw completing at once
    set_ins(6'b001101, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd10), "ori_fetch");
    cyc(Z, 1'b1, dec(32'd10), "ori_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 32'd10), "ori_exec");
    cyc(Z, 1'b1, mk(3'd4, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd10), "ori_wb");
    set_ins(6'b101011, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd11), "sw_fetch");
    cyc(Z, 1'b1, dec(32'd11), "sw_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd11), "sw_exec");
    cyc(Z, 1'b1, mk(3'd3, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'd11), "sw_mem");
    // mem_ready arrives on the 4th wait cycle (TIMEOUT=4): completion, no bus error
    set_ins(6'b001111, 6'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      cyc(Z, 1'b0, fetch(1'b0, 32'd12), "fetch_wait");
    cyc(Z, 1'b1, fetch(1'b1, 32'd12), "fetch_ready_at_limit");
    cyc(Z, 1'b1, dec(32'd12), "lui_decode");
    cyc(Z, 1'b1, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'd12), "lui_exec");
    cyc(Z, 1'b1, mk(3'd4, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd12), "lui_wb");
    // illegal opcode traps in cycle 2 and holds
    set_ins(6'b111111, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd13), "ill_fetch");
    cyc(Z, 1'b1, dec(32'd13), "ill_decode");
    for (int i = 0; i < 3; i++)
      cyc(Z, 1'b1, trp(1'b1, 1'b0, 32'd13), "ill_trap_hold");
    do_reset("reset_from_trap");
    // stuck bus in FETCH: bus error after four wait cycles
    for (int i = 0; i < 4; i++)
      cyc(Z, 1'b0, fetch(1'b0, 32'd0), "fetch_stuck");
    cyc(Z, 1'b0, trp(1'b0, 1'b1, 32'd0), "bus_timeout");
    cyc(Z, 1'b1, trp(1'b0, 1'b1, 32'd0), "bus_err_hold");
    // reset while lw is waiting in MEM
    do_reset("reset_before_lw");
    set_ins(6'b100011, 6'd0, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd0), "lw2_fetch");
    cyc(Z, 1'b1, dec(32'd0), "lw2_decode");
    cyc(Z, 1'b0, mk(3'd2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0), "lw2_exec");
    cyc(Z, 1'b0, mk(3'd3, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd0), "lw2_mem");
    do_reset("reset_mid_mem");
    cyc(Z, 1'b1, fetch(1'b1, 32'd0), "restart_fetch");
    cyc(Z, 1'b1, dec(32'd0), "restart_decode");
    // slt is illegal when the slt family is disabled
    sel = 1'b1;
    do_reset("noslt_reset");
    set_ins(6'b000000, 6'b101010, 5'd0);
    cyc(Z, 1'b1, fetch(1'b1, 32'd0), "noslt_fetch");
    cyc(Z, 1'b1, dec(32'd0), "noslt_decode");
    cyc(Z, 1'b1, trp(1'b1, 1'b0, 32'd0), "noslt_trap");
    cyc(Z, 1'b1, trp(1'b1, 1'b0, 32'd0), "noslt_trap_hold");

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
